fp_wb_arbiter: RTL and testbench

// - Write-back stage feeding the FP register file's single write port (Reg_Wr/Rd_Wr/Rd_In).
// - Arbitrates two result sources, FP load unit (LD) and multi-cycle FPU (FU), via valid/ready handshakes.
// - Keeps a per-register pending scoreboard so issue logic can stall on RAW/WAW hazards against in-flight FP results.

---
 rtl/fp_wb_pkg.sv | 29 ++
 rtl/fp_scoreboard.sv | 45 ++++
 rtl/fp_wb_arbiter.sv | 104 ++++++++++
 tb/tb_fp_wb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types and sizes for the FP write-back arbiter and its scoreboard.
// wb_req_t carries FLEN_DEF-wide data, so the top's FLEN must equal FLEN_DEF.
package fp_wb_pkg;

  localparam int FLEN_DEF  = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_FREGS = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t            rd;
    logic [FLEN_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_FU   = 2'd2
  } wb_src_e;

  function automatic wb_req_t mk_req(input reg_idx_t rd, input logic [FLEN_DEF-1:0] data);
    wb_req_t r;
    r.rd   = rd;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register pending-write bits with four combinational busy lookups.
// A set and a clear of the same index in one cycle leaves the bit set.
module fp_scoreboard
  import fp_wb_pkg::*;
(
  input  logic     CLK,
  input  logic     rst_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1_q,
  input  reg_idx_t rs2_q,
  input  reg_idx_t rs3_q,
  input  reg_idx_t rd_q,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     rs3_busy,
  output logic     rd_busy
);

  logic [NUM_FREGS-1:0] pending_q;
  logic [NUM_FREGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    // applied after the clear so the newer producer keeps the register busy
    if (set_en) pending_d[set_idx] = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_busy = pending_q[rs1_q];
  assign rs2_busy = pending_q[rs2_q];
  assign rs3_busy = pending_q[rs3_q];
  assign rd_busy  = pending_q[rd_q];

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file write-back: arbitrates LD and FU results with an FU
// anti-starvation counter, registers the write, and tracks pending writes.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int FLEN       = FLEN_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [FLEN-1:0]      ld_data,
  output logic                 ld_ready,
  input  logic                 fu_valid,
  input  logic [REG_IDX_W-1:0] fu_rd,
  input  logic [FLEN-1:0]      fu_data,
  output logic                 fu_ready,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1_q,
  input  logic [REG_IDX_W-1:0] rs2_q,
  input  logic [REG_IDX_W-1:0] rs3_q,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rs3_busy,
  output logic                 rd_busy,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [FLEN-1:0]      wb_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  wb_src_e          grant;
  wb_req_t          sel_req;
  logic             wb_en_q;
  wb_req_t          wb_q;

  always_comb begin
    grant    = SRC_NONE;
    sel_req  = mk_req(ld_rd, ld_data);
    starve_d = starve_q;

    if (fu_valid && ((starve_q == STARVE_LIM) || !ld_valid)) begin
      grant = SRC_FU;
    end else if (ld_valid) begin
      grant = SRC_LD;
    end

    if (grant == SRC_FU) begin
      sel_req = mk_req(fu_rd, fu_data);
    end

    // counts only cycles in which a waiting FU result loses to LD
    if (!fu_valid || (grant == SRC_FU)) begin
      starve_d = '0;
    end else if ((grant == SRC_LD) && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign ld_ready = rst_n && (grant == SRC_LD);
  assign fu_ready = rst_n && (grant == SRC_FU);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      wb_en_q  <= 1'b0;
      wb_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wb_en_q  <= (grant != SRC_NONE);
      if (grant != SRC_NONE) begin
        wb_q <= sel_req;
      end
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_q.rd;
  assign wb_data = wb_q.data;

  fp_scoreboard u_scoreboard (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .set_en   (issue_valid),
    .set_idx  (issue_rd),
    .clr_en   (wb_en_q),
    .clr_idx  (wb_q.rd),
    .rs1_q    (rs1_q),
    .rs2_q    (rs2_q),
    .rs3_q    (rs3_q),
    .rd_q     (issue_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rs3_busy (rs3_busy),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of grants and pending writes.
module tb_fp_wb_arbiter;

  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        ld_valid, fu_valid, issue_valid;
  logic [4:0]  ld_rd, fu_rd, issue_rd, rs1_q, rs2_q, rs3_q;
  logic [31:0] ld_data, fu_data;
  logic        ld_ready, fu_ready, rs1_busy, rs2_busy, rs3_busy, rd_busy;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  fp_wb_arbiter #(.FLEN(32), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .fu_valid(fu_valid), .fu_rd(fu_rd), .fu_data(fu_data), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rs3_q(rs3_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs3_busy(rs3_busy), .rd_busy(rd_busy),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_pending [32];
  int          m_starve;
  bit          m_wb_en;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  bit          m_ld_won, m_fu_won;

  // DUT values sampled at the last negedge
  logic        s_ld_ready, s_fu_ready, s_wb_en, s_rs1_busy, s_rs2_busy, s_rd_busy;
  logic [4:0]  s_wb_rd;
  logic [31:0] s_wb_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pending[i]) m_pending[i] = 1'b0;
    m_starve  = 0;
    m_wb_en   = 1'b0;
    m_wb_rd   = '0;
    m_wb_data = '0;
    m_ld_won  = 1'b0;
    m_fu_won  = 1'b0;
  endtask

  // One clock: compare at negedge, advance the model across the posedge.
  task automatic step();
    bit fu_win, ld_win;
    @(negedge CLK);
    if (!rst_n) model_reset();
    fu_win = rst_n && fu_valid && (m_starve == SM || !ld_valid);
    ld_win = rst_n && ld_valid && !fu_win;
    s_ld_ready = ld_ready;  s_fu_ready = fu_ready;
    s_wb_en = wb_en;  s_wb_rd = wb_rd;  s_wb_data = wb_data;
    s_rs1_busy = rs1_busy;  s_rs2_busy = rs2_busy;  s_rd_busy = rd_busy;
    chk("ld_ready", ld_ready, ld_win);
    chk("fu_ready", fu_ready, fu_win);
    chk("wb_en", wb_en, m_wb_en);
    if (m_wb_en) begin
      chk("wb_rd", wb_rd, m_wb_rd);
      chk("wb_data", wb_data, m_wb_data);
    end
    chk("rs1_busy", rs1_busy, m_pending[rs1_q]);
    chk("rs2_busy", rs2_busy, m_pending[rs2_q]);
    chk("rs3_busy", rs3_busy, m_pending[rs3_q]);
    chk("rd_busy", rd_busy, m_pending[issue_rd]);
    if (issue_valid) chk("issue_while_busy", rd_busy, 1'b0);
    @(posedge CLK);
    if (rst_n) begin
      if (m_wb_en) m_pending[m_wb_rd] = 1'b0;
      if (issue_valid) m_pending[issue_rd] = 1'b1;
      m_wb_en = fu_win || ld_win;
      if (fu_win) begin
        m_wb_rd = fu_rd;  m_wb_data = fu_data;
      end else if (ld_win) begin
        m_wb_rd = ld_rd;  m_wb_data = ld_data;
      end
      if (fu_win || !fu_valid) m_starve = 0;
      else if (ld_win && m_starve < SM) m_starve = m_starve + 1;
    end else begin
      model_reset();
    end
    m_ld_won = ld_win;
    m_fu_won = fu_win;
    #1;
  endtask

  function automatic logic [4:0] pick_rd();
    int r = int'($urandom_range(0, 31));
    if ($urandom_range(0, 3) != 0) begin
      for (int k = 0; k < 32; k++) begin
        if (m_pending[(r + k) % 32]) return 5'((r + k) % 32);
      end
    end
    return 5'(r);
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    ld_valid = 1'b1;  ld_rd = 5'd1;  ld_data = 32'h1111;
    fu_valid = 1'b1;  fu_rd = 5'd2;  fu_data = 32'h2222;
    issue_valid = 1'b0;  issue_rd = '0;
    rs1_q = '0;  rs2_q = '0;  rs3_q = '0;

    // reset with both sources valid
    step();
    chk("rst_ld_ready", s_ld_ready, 1'b0);
    chk("rst_fu_ready", s_fu_ready, 1'b0);
    chk("rst_wb_en", s_wb_en, 1'b0);
    step();

    // single LD result
    rst_n = 1'b1;
    fu_valid = 1'b0;
    ld_rd = 5'd3;  ld_data = 32'h3F80_0000;
    step();
    chk("ld_only_ready", s_ld_ready, 1'b1);
    chk("ld_only_wb_early", s_wb_en, 1'b0);
    ld_valid = 1'b0;
    step();
    chk("ld_only_wb_en", s_wb_en, 1'b1);
    chk("ld_only_wb_rd", s_wb_rd, 5'd3);
    chk("ld_only_wb_data", s_wb_data, 32'h3F80_0000);

    // both continuously valid: LD x4 then FU, repeating
    ld_valid = 1'b1;  fu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ld_data = $urandom;  fu_data = $urandom;
      step();
      chk("starve_fu_ready", s_fu_ready, (i % 5 == 4));
      chk("starve_ld_ready", s_ld_ready, (i % 5 != 4));
    end
    ld_valid = 1'b0;  fu_valid = 1'b0;
    step();

    // RAW on rd 7, cleared by an FU write
    issue_valid = 1'b1;  issue_rd = 5'd7;  rs1_q = 5'd7;
    step();
    chk("raw_busy_before", s_rs1_busy, 1'b0);
    issue_valid = 1'b0;
    step();
    chk("raw_busy_set", s_rs1_busy, 1'b1);
    fu_valid = 1'b1;  fu_rd = 5'd7;  fu_data = 32'h4000_0000;
    step();
    fu_valid = 1'b0;
    step();
    chk("raw_wb_rd", s_wb_rd, 5'd7);
    chk("raw_busy_during_wb", s_rs1_busy, 1'b1);
    step();
    chk("raw_busy_cleared", s_rs1_busy, 1'b0);

    // issue rd 5 in the same cycle as the write-back to 5
    ld_valid = 1'b1;  ld_rd = 5'd5;  ld_data = 32'h5555_0000;
    step();
    ld_valid = 1'b0;
    issue_valid = 1'b1;  issue_rd = 5'd5;  rs2_q = 5'd5;
    step();
    chk("same_cyc_wb_en", s_wb_en, 1'b1);
    chk("same_cyc_wb_rd", s_wb_rd, 5'd5);
    issue_valid = 1'b0;
    step();
    chk("same_cyc_set_wins", s_rs2_busy, 1'b1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      if (!(ld_valid && !m_ld_won)) begin
        ld_valid = ($urandom_range(0, 99) < 60);
        ld_rd = pick_rd();  ld_data = $urandom;
      end
      if (!(fu_valid && !m_fu_won)) begin
        fu_valid = ($urandom_range(0, 99) < 55);
        fu_rd = pick_rd();  fu_data = $urandom;
      end
      r = int'($urandom_range(0, 31));
      issue_rd = 5'(r);
      issue_valid = ($urandom_range(0, 2) == 0) && !m_pending[r];
      rs1_q = 5'($urandom_range(0, 31));
      rs2_q = 5'($urandom_range(0, 31));
      rs3_q = 5'($urandom_range(0, 31));
      step();
    end

    // async reset in the middle of a back-to-back stream
    issue_valid = 1'b0;
    ld_valid = 1'b1;  fu_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("stream_wb_en", s_wb_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wb_en", wb_en, 1'b0);
    chk("async_rst_busy1", rs1_busy, 1'b0);
    chk("async_rst_busy2", rs2_busy, 1'b0);
    chk("async_rst_ready", ld_ready | fu_ready, 1'b0);
    step();
    rst_n = 1'b1;
    ld_valid = 1'b0;  fu_valid = 1'b0;
    step();
    step();
    chk("post_rst_no_wb", s_wb_en, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
